// File: rtl/loop_pkg.sv
// Shared types and constants for the loop recorder/player.
// State encoding, pad/voice index names, and the stored-entry width helper.
// Used by loop_sequencer and loop_event_ram.
package loop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  // Voice index = bit position in a pad/trigger mask
  localparam int CYMBAL = 0;
  localparam int HIHAT  = 1;
  localparam int TOM    = 2;
  localparam int SNARE  = 3;
  localparam int KICK   = 4;

  // One stored event is {timestamp, voice mask}
  function automatic int entry_width(input int ts_width, input int num_voices);
    return ts_width + num_voices;
  endfunction

endpackage

// File: rtl/loop_event_ram.sv
// Event store: DEPTH entries of {timestamp, voice mask}.
// Synchronous write, asynchronous (same-cycle) read so a scan can visit one entry per clock.
// No reset: contents are only meaningful below the owner's event count.
module loop_event_ram
  import loop_pkg::*;
#(
  parameter int NUM_VOICES = 5,
  parameter int DEPTH      = 128,
  parameter int TS_WIDTH   = 17,
  parameter int AW         = 7,
  parameter int EW         = entry_width(TS_WIDTH, NUM_VOICES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/loop_sequencer.sv
// Multi-voice loop recorder/player: timestamps pad edges, replays them as one-cycle triggers, supports overdub.
// Trigger appears event_count+1 clocks after the sample_tick that starts a scan.
// No backpressure; edges arriving when memory is full are dropped, ticks arriving mid-scan start no scan.
module loop_sequencer
  import loop_pkg::*;
#(
  parameter int NUM_VOICES = 5,
  parameter int DEPTH      = 128,
  parameter int TS_WIDTH   = 17,
  parameter int MAX_TICKS  = 72500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_tick,
  input  logic                         rec_en,
  input  logic                         play_en,
  input  logic                         overdub_en,
  input  logic                         clear,
  input  logic [NUM_VOICES-1:0]        pad_pressed,
  output logic [NUM_VOICES-1:0]        play_trig,
  output logic                         rec_done,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   event_count,
  output logic [TS_WIDTH-1:0]          loop_length
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = entry_width(TS_WIDTH, NUM_VOICES);

  state_t                state, state_nxt;
  logic                  enter_rec, leave_rec, enter_play, in_rec, in_play;
  logic                  rec_write, dub_write, ram_we;
  logic [EW-1:0]         ram_wdata, rd_data;
  logic [NUM_VOICES-1:0] pad_prev, pad_edge, rd_mask, hit;
  logic [TS_WIDTH-1:0]   rec_ts, play_ts, scan_ts, rd_ts;
  logic                  scanning;
  logic [CW-1:0]         scan_idx, scan_last;
  logic [NUM_VOICES-1:0] scan_acc;

  assign pad_edge = pad_pressed & ~pad_prev;
  assign rd_ts    = rd_data[EW-1:NUM_VOICES];
  assign rd_mask  = rd_data[NUM_VOICES-1:0];
  assign hit      = (rd_ts == scan_ts) ? rd_mask : '0;

  loop_event_ram #(
    .NUM_VOICES (NUM_VOICES),
    .DEPTH      (DEPTH),
    .TS_WIDTH   (TS_WIDTH),
    .AW         (AW),
    .EW         (EW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (event_count[AW-1:0]),
    .wdata (ram_wdata),
    .raddr (scan_idx[AW-1:0]),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, transition strobes and write enables; clear beats rec_en beats play_en
  always_comb begin
    state_nxt  = state;
    enter_rec  = 1'b0;
    leave_rec  = 1'b0;
    enter_play = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rec_en) begin
            state_nxt = REC;
            enter_rec = 1'b1;
          end else if (play_en && loop_length != '0) begin
            state_nxt  = PLAY;
            enter_play = 1'b1;
          end
        end
        REC: begin
          if (!rec_en) begin
            state_nxt = IDLE;
            leave_rec = 1'b1;
          end
        end
        PLAY: begin
          if (rec_en) begin
            state_nxt = REC;
            enter_rec = 1'b1;
          end else if (!play_en) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    in_rec    = (state == REC)  && (state_nxt == REC);
    in_play   = (state == PLAY) && (state_nxt == PLAY);
    rec_write = in_rec && (pad_edge != '0) && !full && !rec_done;
    dub_write = in_play && overdub_en && (pad_edge != '0) && !full;
    ram_we    = rec_write || dub_write;
    ram_wdata = {(rec_write ? rec_ts : play_ts), pad_edge};
  end

  // Previous pad levels for edge detection, tracked in every state
  always_ff @(posedge clk) begin
    if (rst) pad_prev <= '0;
    else     pad_prev <= pad_pressed;
  end

  // Recording, playback position, scan engine and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      play_trig   <= '0;
      rec_done    <= 1'b0;
      full        <= 1'b0;
      event_count <= '0;
      loop_length <= '0;
      rec_ts      <= '0;
      play_ts     <= '0;
      scan_ts     <= '0;
      scanning    <= 1'b0;
      scan_idx    <= '0;
      scan_last   <= '0;
      scan_acc    <= '0;
    end else begin
      play_trig <= '0;
      if (clear || enter_rec) begin
        // event_count doubles as the write pointer, so zeroing it discards the loop
        event_count <= '0;
        full        <= 1'b0;
        loop_length <= '0;
        rec_done    <= 1'b0;
        rec_ts      <= '0;
        scanning    <= 1'b0;
      end else begin
        if (ram_we) begin
          event_count <= event_count + 1'b1;
          full        <= (event_count + 1'b1) == CW'(DEPTH);
        end
        if (in_rec) begin
          if (sample_tick && rec_ts < TS_WIDTH'(MAX_TICKS - 1)) begin
            rec_ts <= rec_ts + 1'b1;
            if (rec_ts == TS_WIDTH'(MAX_TICKS - 2)) rec_done <= 1'b1;
          end
          if (rec_write && event_count == CW'(DEPTH - 1)) rec_done <= 1'b1;
        end
        if (leave_rec) loop_length <= rec_ts + 1'b1;
        if (enter_play) play_ts <= '0;
        if (in_play) begin
          if (sample_tick) begin
            play_ts <= (play_ts == loop_length - 1'b1) ? '0 : play_ts + 1'b1;
            // Snapshot the count so entries appended during this scan wait for the next pass
            if (!scanning && event_count != '0) begin
              scanning  <= 1'b1;
              scan_ts   <= play_ts;
              scan_idx  <= '0;
              scan_last <= event_count - 1'b1;
              scan_acc  <= '0;
            end
          end
          if (scanning) begin
            if (scan_idx == scan_last) begin
              play_trig <= scan_acc | hit;
              scanning  <= 1'b0;
            end else begin
              scan_idx <= scan_idx + 1'b1;
              scan_acc <= scan_acc | hit;
            end
          end
        end else begin
          scanning <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer with a small memory and short recording cap.
// Reference keeps the loop as a list of {tick, mask} events and predicts triggers per playback position.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_loop_sequencer;
  import loop_pkg::*;

  localparam int NV   = 5;
  localparam int DEP  = 8;
  localparam int TSW  = 8;
  localparam int MAXT = 50;
  localparam int GAP  = 20;

  logic           clk = 1'b0;
  logic           rst, sample_tick, rec_en, play_en, overdub_en, clear;
  logic [NV-1:0]  pad_pressed, play_trig;
  logic           rec_done, full;
  logic [3:0]     event_count;
  logic [TSW-1:0] loop_length;

  int checks = 0;
  int errors = 0;

  int            q_ts[$];
  logic [NV-1:0] q_mask[$];
  int            m_rts, m_len, m_pos;
  bit            m_done;
  logic [NV-1:0] plan_mask[64];
  bit            plan_same[64];

  loop_sequencer #(.NUM_VOICES(NV), .DEPTH(DEP), .TS_WIDTH(TSW), .MAX_TICKS(MAXT)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rec_en(rec_en), .play_en(play_en),
    .overdub_en(overdub_en), .clear(clear), .pad_pressed(pad_pressed), .play_trig(play_trig),
    .rec_done(rec_done), .full(full), .event_count(event_count), .loop_length(loop_length)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV-1:0] model_hits(input int pos);
    logic [NV-1:0] m = '0;
    foreach (q_ts[i]) if (q_ts[i] == pos) m |= q_mask[i];
    return m;
  endfunction

  // A recorded edge is kept only while there is room and the cap is not reached
  task automatic model_push(input logic [NV-1:0] m);
    if (q_ts.size() < DEP && m_rts < MAXT - 1) begin
      q_ts.push_back(m_rts);
      q_mask.push_back(m);
      if (q_ts.size() == DEP) m_done = 1'b1;
    end
  endtask

  task automatic model_tick();
    if (m_rts < MAXT - 1) m_rts++;
    if (m_rts == MAXT - 1) m_done = 1'b1;
  endtask

  task automatic clear_plan();
    for (int t = 0; t < 64; t++) begin
      plan_mask[t] = '0;
      plan_same[t] = 1'b0;
    end
  endtask

  // Record a loop covering recording ticks 0..len-1, pressing plan_mask[t] during tick t
  task automatic record(input int len);
    q_ts.delete();
    q_mask.delete();
    m_rts  = 0;
    m_done = 1'b0;
    play_en = 1'b0;
    rec_en  = 1'b1;
    cyc(1);
    for (int t = 0; t < len; t++) begin
      if (plan_mask[t] != '0) begin
        pad_pressed = plan_mask[t];
        if (plan_same[t] && t < len - 1) sample_tick = 1'b1;
        cyc(1);
        pad_pressed = '0;
        model_push(plan_mask[t]);
        if (sample_tick) model_tick();
        check($sformatf("rec_count_t%0d", t), event_count, q_ts.size());
        if (sample_tick) begin
          sample_tick = 1'b0;
          cyc(1);
          check($sformatf("rec_done_t%0d", t), rec_done, m_done);
          continue;
        end
        cyc(1);
      end
      if (t < len - 1) begin
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        model_tick();
        check($sformatf("rec_done_t%0d", t), rec_done, m_done);
        cyc(1);
      end
    end
    rec_en = 1'b0;
    cyc(1);
    m_len = m_rts + 1;
    check("loop_length", loop_length, m_len);
    check("event_count", event_count, q_ts.size());
    check("full", full, q_ts.size() == DEP);
    check("rec_done", rec_done, m_done);
  endtask

  task automatic start_play();
    play_en = 1'b1;
    cyc(1);
    m_pos = 0;
  endtask

  // One playback tick (optionally with an overdub edge in the same cycle), then watch every cycle
  task automatic play_tick(input logic [NV-1:0] dub);
    logic [NV-1:0] exp;
    int n;
    exp = model_hits(m_pos);
    n   = q_ts.size();
    sample_tick = 1'b1;
    if (dub != '0) begin
      pad_pressed = dub;
      overdub_en  = 1'b1;
    end
    cyc(1);
    sample_tick = 1'b0;
    pad_pressed = '0;
    overdub_en  = 1'b0;
    if (dub != '0 && n < DEP) begin
      q_ts.push_back(m_pos);
      q_mask.push_back(dub);
    end
    for (int c = 1; c < GAP; c++) begin
      cyc(1);
      check($sformatf("trig_p%0d_c%0d", m_pos, c), play_trig, (c == n) ? exp : '0);
    end
    m_pos = (m_pos + 1) % m_len;
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0; rec_en = 1'b0; play_en = 1'b0;
    overdub_en = 1'b0; clear = 1'b0; pad_pressed = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_trig", play_trig, 0);
    check("rst_done", rec_done, 0);
    check("rst_full", full, 0);
    check("rst_count", event_count, 0);
    check("rst_len", loop_length, 0);

    // Kick at tick 3, snare+hihat together at tick 7, stop at tick 10
    clear_plan();
    plan_mask[3] = NV'(1 << KICK);
    plan_mask[7] = NV'((1 << SNARE) | (1 << HIHAT));
    record(11);
    check("a_len", loop_length, 11);
    start_play();
    for (int i = 0; i < 22; i++) play_tick('0);

    // Overdub tom together with the tick that plays position 5
    for (int i = 0; i < 5; i++) play_tick('0);
    play_tick(NV'(1 << TOM));
    check("dub_count", event_count, 3);
    for (int i = 0; i < 12; i++) play_tick('0);

    // Clear in the middle of a scan
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("clr_trig", play_trig, 0);
      cyc(1);
    end
    check("clr_count", event_count, 0);
    check("clr_len", loop_length, 0);
    check("clr_full", full, 0);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      check("clr_noplay", play_trig, 0);
    end
    play_en = 1'b0;

    // Ten edges into an eight-entry memory
    clear_plan();
    for (int t = 0; t < 10; t++) plan_mask[t] = NV'($urandom_range(1, 31));
    record(11);
    check("d_full", full, 1);
    check("d_done", rec_done, 1);
    check("d_count", event_count, DEP);
    start_play();
    for (int i = 0; i < 22; i++) play_tick('0);

    // Random loops with some edges landing on the tick cycle, then an aborted scan
    for (int r = 0; r < 2; r++) begin
      int len;
      clear_plan();
      len = $urandom_range(4, 14);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 1) == 1) plan_mask[t] = NV'($urandom_range(1, 31));
        plan_same[t] = ($urandom_range(0, 2) == 0);
      end
      record(len);
      start_play();
      for (int i = 0; i < 2 * len; i++) play_tick('0);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      play_en = 1'b0;
      for (int c = 0; c < 12; c++) begin
        cyc(1);
        check("abort_trig", play_trig, 0);
      end
      start_play();
      for (int i = 0; i < 3; i++) play_tick('0);
    end

    // Recording held past the tick cap
    clear_plan();
    plan_mask[10] = NV'(1 << KICK);
    plan_mask[48] = NV'(1 << SNARE);
    plan_same[48] = 1'b1;
    plan_mask[49] = NV'(1 << CYMBAL);
    plan_mask[55] = NV'(1 << TOM);
    record(60);
    check("cap_len", loop_length, MAXT);
    check("cap_count", event_count, 2);
    start_play();
    for (int i = 0; i < 52; i++) play_tick('0);

    // Reset in the middle of a recording
    rec_en = 1'b1;
    cyc(1);
    pad_pressed = NV'(1 << HIHAT);
    cyc(1);
    pad_pressed = '0;
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    check("pre_rst_count", event_count, 1);
    rst = 1'b1;
    rec_en = 1'b0;
    play_en = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("rst2_trig", play_trig, 0);
    check("rst2_done", rec_done, 0);
    check("rst2_full", full, 0);
    check("rst2_count", event_count, 0);
    check("rst2_len", loop_length, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
